seq_adder: RTL and testbench

Parametrised multi-cycle add/subtract unit. It processes an N-bit operand pair in CHUNK-bit slices, one slice per clock, rippling carry between slices through a register. Operands enter and results leave through a start/ready/done handshake. It supersedes the purely combinational 16-bit adder top in the adder DFT example, trading latency for a short carry chain that is friendly to scan insertion.

---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_slice.sv | 26 ++
 rtl/seq_adder.sv | 128 ++++++++++++
 tb/tb_seq_adder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the sequential adder.
// Imported by seq_adder and adder_slice.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nc(input int n, input int chunk);
    return n / chunk;
  endfunction

  function automatic int calc_cw(input int nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// cm is the carry into the slice MSB, used for signed overflow.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cm
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[W];
  assign cm = c[W-1];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle add/subtract, one CHUNK slice per clock.
// Optional signed overflow output: define SEQ_ADDER_OVF_EN.
module seq_adder
  import adder_pkg::*;
#(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         pin_clk,
  input  logic         pin_rst_n,
  input  logic         pin_start,
  output logic         pin_ready,
  input  logic [N-1:0] pin_a,
  input  logic [N-1:0] pin_b,
  input  logic         pin_cin,
  input  logic         pin_sel,
  output logic [N-1:0] pin_sum,
  output logic         pin_co,
  output logic         pin_done
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic         pin_ovf
`endif
);

  localparam int NC = calc_nc(N, CHUNK);
  localparam int CW = calc_cw(NC);

  if ((N % CHUNK) != 0 || N < CHUNK) begin : g_bad_cfg
    $error("seq_adder: N must be a multiple of CHUNK and >= CHUNK");
  end

  state_t          state;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    work;
  logic [N-1:0]    work_nx;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] s_sl;
  logic            co_sl;
  logic            cm_sl;
  logic            last;

  assign a_sl = a_q[int'(cnt)*CHUNK +: CHUNK];
  assign b_sl = b_q[int'(cnt)*CHUNK +: CHUNK];
  assign last = (cnt == CW'(NC - 1));

  adder_slice #(
    .W (CHUNK)
  ) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry),
    .s  (s_sl),
    .co (co_sl),
    .cm (cm_sl)
  );

`ifndef SEQ_ADDER_OVF_EN
  logic unused_cm;
  assign unused_cm = cm_sl;
`endif

  // Working register with the current slice merged in.
  always_comb begin
    work_nx = work;
    work_nx[int'(cnt)*CHUNK +: CHUNK] = s_sl;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      work      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      pin_ready <= 1'b1;
      pin_sum   <= '0;
      pin_co    <= 1'b0;
      pin_done  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      pin_ovf   <= 1'b0;
`endif
    end else begin
      pin_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pin_start) begin
            a_q       <= pin_a;
            b_q       <= pin_sel ? ~pin_b : pin_b;
            carry     <= pin_cin;
            cnt       <= '0;
            pin_ready <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          work  <= work_nx;
          carry <= co_sl;
          cnt   <= cnt + 1'b1;
          if (last) begin
            pin_sum  <= work_nx;
            pin_co   <= co_sl;
            pin_done <= 1'b1;
`ifdef SEQ_ADDER_OVF_EN
            pin_ovf  <= cm_sl ^ co_sl;
`endif
            state    <= DONE;
          end
        end
        DONE: begin
          pin_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          pin_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: vector table, random ops,
// handshake and mid-operation reset sequences.
module tb_seq_adder;

  localparam int N     = 16;
  localparam int CHUNK = 4;
  localparam int NC    = N / CHUNK;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sel;
  logic [N-1:0] sum;
  logic         co;
  logic         done;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  seq_adder #(
    .N     (N),
    .CHUNK (CHUNK)
  ) dut (
    .pin_clk   (clk),
    .pin_rst_n (rst_n),
    .pin_start (start),
    .pin_ready (ready),
    .pin_a     (a),
    .pin_b     (b),
    .pin_cin   (cin),
    .pin_sel   (sel),
    .pin_sum   (sum),
    .pin_co    (co),
    .pin_done  (done)
`ifdef SEQ_ADDER_OVF_EN
    ,
    .pin_ovf   (ovf)
`endif
  );

`ifndef SEQ_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sel;
    logic [N-1:0] sum;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain N+1 bit arithmetic and sign-rule overflow.
  task automatic model(input logic [N-1:0] ma,
                       input logic [N-1:0] mb,
                       input logic mcin,
                       input logic msel,
                       output logic [N-1:0] msum,
                       output logic mco,
                       output logic movf);
    logic [N:0] full;
    logic [N-1:0] bb;
    bb = msel ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{N{1'b0}}, mcin};
    msum = full[N-1:0];
    mco  = full[N];
    movf = (ma[N-1] == bb[N-1]) && (msum[N-1] != ma[N-1]);
  endtask

  task automatic run_op(input logic [N-1:0] ta,
                        input logic [N-1:0] tb,
                        input logic tcin,
                        input logic tsel,
                        output logic [N-1:0] rsum,
                        output logic rco,
                        output logic rovf,
                        output int lat);
    int k;
    bit got;
    k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    a = ta;
    b = tb;
    cin = tcin;
    sel = tsel;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ready_low_in_run", 32'(ready), 32'd0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 32'(done), 32'd1);
    rsum = sum;
    rco  = co;
    rovf = ovf;
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [N-1:0] rs;
    logic rc;
    logic ro;
    int lat;
    logic [N-1:0] es;
    logic ec;
    logic eo;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic rcin;
    logic rsel;
    int acc_edge;
    int dones;
    logic [N-1:0] first_sum;
    bit rdy;
    bit got;
    int k;

    vecs[0] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[1] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h000F, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    sel = 1'b0;
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sel,
             rs, rc, ro, lat);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].sum));
      check($sformatf("vec%0d_co", i), 32'(rc), 32'(vecs[i].co));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(NC));
`ifdef SEQ_ADDER_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].ovf));
`endif
    end

    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rcin = 1'($urandom_range(1));
      rsel = 1'($urandom_range(1));
      model(ra, rb, rcin, rsel, es, ec, eo);
      run_op(ra, rb, rcin, rsel, rs, rc, ro, lat);
      check($sformatf("rnd%0d_sum", i), 32'(rs), 32'(es));
      check($sformatf("rnd%0d_co", i), 32'(rc), 32'(ec));
`ifdef SEQ_ADDER_OVF_EN
      check($sformatf("rnd%0d_ovf", i), 32'(ro), 32'(eo));
`endif
    end

    // Handshake: start held high, operand changes after acceptance.
    k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    a = 16'h1234;
    b = 16'h1111;
    cin = 1'b0;
    sel = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'hFFFF;
    acc_edge = 0;
    dones = 0;
    first_sum = '0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      rdy = ready;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        first_sum = sum;
      end
      if (rdy) begin
        acc_edge = e;
        break;
      end
    end
    start = 1'b0;
    check("hs_second_accept_edge", 32'(acc_edge), 32'd6);
    check("hs_done_count", 32'(dones), 32'd1);
    check("hs_first_sum", 32'(first_sum), 32'h2345);
    got = 1'b0;
    for (int e = 0; e < 12 && !got; e++) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
    end
    check("hs_second_done", 32'(got), 32'd1);
    check("hs_second_sum", 32'(sum), 32'h1110);
    check("hs_second_co", 32'(co), 32'd1);

    // Reset during RUN.
    k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    a = 16'h00FF;
    b = 16'h0F01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_co", 32'(co), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("mid_rst_no_done", 32'(dones), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    check("post_rst_sum", 32'(rs), 32'h0002);
    check("post_rst_co", 32'(rc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
